// File: rtl/uart_mode_ctrl_pkg.sv
// Shared types, command characters and rate-table lookup for the UART mode controller.
package mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CTRL  = 2'd1,
    ST_CLEAN = 2'd2
  } state_t;

  localparam logic [7:0] CH_M   = 8'h4D;
  localparam logic [7:0] CH_F   = 8'h46;
  localparam logic [7:0] CH_C   = 8'h43;
  localparam logic [7:0] CH_NUL = 8'h00;

  localparam int MAX_RATES = 4;
  localparam logic [7:0] RATE_CH [MAX_RATES] = '{8'h31, 8'h35, 8'h41, 8'h42};

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } rate_hit_t;

  // Upper-case form or its lower-case twin; digits map onto themselves.
  function automatic logic is_char(input logic [7:0] b, input logic [7:0] ch);
    return (b == ch) || (b == (ch | 8'h20));
  endfunction

  function automatic rate_hit_t rate_index(input logic [7:0] b, input int num);
    rate_hit_t r;
    r = '0;
    for (int i = 0; i < MAX_RATES; i++) begin
      if (!r.hit && (i < num) && is_char(b, RATE_CH[i])) begin
        r.hit = 1'b1;
        r.idx = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_mode_ctrl_if.sv
// Byte-stream, downstream handshake and status signals of the UART mode controller.
interface uart_mode_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int RATE_W = 2,
  parameter int CNT_W  = 3
);
  logic              iVALID;
  logic [DATA_W-1:0] idata;
  logic              iREADY;
  logic [DATA_W-1:0] oData;
  logic              oWRen;
  logic [RATE_W-1:0] orate_control;
  logic              oTX_RATE_STATE;
  logic              oSTART;
  logic              oCLEAN;
  logic              oERR;
  logic [CNT_W-1:0]  oBUF_CNT;

  modport slave (
    input  iVALID, idata, iREADY,
    output oData, oWRen, orate_control, oTX_RATE_STATE, oSTART, oCLEAN, oERR, oBUF_CNT
  );

  modport master (
    output iVALID, idata, iREADY,
    input  oData, oWRen, orate_control, oTX_RATE_STATE, oSTART, oCLEAN, oERR, oBUF_CNT
  );
endinterface

// File: rtl/uart_mode_ctrl_cmd_fifo.sv
// Synchronous FIFO; head and count come straight from registers, flush wins over push/pop.
module cmd_fifo #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4,
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(BUF_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mode_ctrl.sv
// Parses received bytes into mode/rate commands and buffers plain data for downstream.
// All outputs registered; every byte's effect is visible one cycle after it is presented.
module uart_mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int RATE_W    = 2,
  parameter int NUM_RATES = 3,
  parameter int BUF_DEPTH = 4,
  parameter int TIMEOUT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  uart_mode_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state, state_nx;
  logic [RATE_W-1:0] rate_q, rate_nx;
  logic              err_q, err_nx, start_q;
  logic              push, pop, flush, full, empty;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic [TO_W-1:0]   to_cnt;
  logic              to_fire;
  logic [7:0]        ch;
  rate_hit_t         rh;

  assign ch      = bus.idata[7:0];
  assign rh      = rate_index(ch, NUM_RATES);
  assign pop     = !empty && bus.iREADY && !flush;
  assign to_fire = (TIMEOUT != 0) && (state == ST_CTRL) && !bus.iVALID && (to_cnt >= TO_LIM);

  always_comb begin
    state_nx = state;
    rate_nx  = rate_q;
    err_nx   = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.iVALID) begin
          if (is_char(ch, CH_M)) begin
            state_nx = ST_CTRL;
          end else if (is_char(ch, CH_C)) begin
            // Flush and rate clear take effect on entry so they line up with oCLEAN.
            state_nx = ST_CLEAN;
            flush    = 1'b1;
            rate_nx  = '0;
          end else if (is_char(ch, CH_F) || ch == CH_NUL) begin
            state_nx = ST_IDLE;
          end else if (full && !bus.iREADY) begin
            err_nx = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_CTRL: begin
        if (bus.iVALID) begin
          if (is_char(ch, CH_F)) begin
            state_nx = ST_IDLE;
          end else if (rh.hit) begin
            rate_nx = RATE_W'(rh.idx);
          end else if (!is_char(ch, CH_M)) begin
            err_nx = 1'b1;
          end
        end else if (to_fire) begin
          state_nx = ST_IDLE;
          err_nx   = 1'b1;
        end
      end
      ST_CLEAN: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rate_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      rate_q  <= rate_nx;
      err_q   <= err_nx;
      start_q <= (state_nx != ST_CTRL);
    end
  end

  // Holds the number of cycles elapsed since the last byte, so it reads 1 one cycle after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= TO_W'(1);
    end else if (bus.iVALID || state != ST_CTRL) begin
      to_cnt <= TO_W'(1);
    end else if (to_cnt < TO_LIM) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  cmd_fifo #(
    .DATA_W   (DATA_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wr_data(bus.idata),
    .rd_data(head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign bus.oData          = head;
  assign bus.oWRen          = !empty;
  assign bus.orate_control  = rate_q;
  assign bus.oTX_RATE_STATE = (state == ST_CTRL);
  assign bus.oSTART         = start_q;
  assign bus.oCLEAN         = (state == ST_CLEAN);
  assign bus.oERR           = err_q;
  assign bus.oBUF_CNT       = count;

endmodule

// File: doc/uart_mode_ctrl.md
# uart_mode_ctrl

Parametrised successor to the UART mode controller. It sits between the UART receiver and the transmit/rate logic and parses the received byte stream:
- command characters select control mode, set the baud-rate code, or clear.
- all other bytes are buffered in an internal FIFO and handed downstream with a ready/valid handshake.

It adds a byte-valid strobe, configurable rate table size, FIFO depth, a control-mode timeout, and error reporting.

## Interface
- DATA_W, 8, received byte width (command chars compared on low 8 bits)
- RATE_W, 2, width of rate code
- NUM_RATES, 3, number of accepted rate characters (1..4)
- BUF_DEPTH, 4, data FIFO depth (power of 2, ≥2)
- TIMEOUT, 0, idle cycles in CTRL before forced exit; 0 disables

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- iVALID  in  1  one-cycle strobe: idata holds a new byte
- idata  in  DATA_W  received byte
- iREADY  in  1  downstream accepts oData this cycle
- oData  out  DATA_W  FIFO head byte
- oWRen  out  1  oData valid (FIFO not empty)
- orate_control  out  RATE_W  current rate code
- oTX_RATE_STATE  out  1  high while in CTRL
- oSTART  out  1  transmit enable, low while in CTRL
- oCLEAN  out  1  one-cycle clear pulse
- oERR  out  1  one-cycle error pulse
- oBUF_CNT  out  $clog2(BUF_DEPTH+1)  FIFO occupancy

## Operation
- States: IDLE, CTRL, CLEAN. Only cycles with iVALID=1 are processed; idata is ignored otherwise.
- IDLE + byte:
  - 'M'/'m' → CTRL.
  - 'C'/'c' → CLEAN.
  - 'F'/'f' or 0x00 → ignored.
  - Any other byte → pushed to the FIFO.
  - Push while full with no simultaneous pop → byte dropped, oERR pulse.
- CTRL + byte:
  - 'F'/'f' → IDLE.
  - Rate char with index < NUM_RATES → orate_control = index; stay in CTRL.
  - Rate table: '1'=0, '5'=1, 'A'/'a'=2, 'B'/'b'=3.
  - 'M'/'m' → ignored.
  - Anything else → oERR pulse; stay in CTRL; nothing pushed.
- CTRL timeout (TIMEOUT>0): counter clears on every iVALID and on CTRL entry. Reaching TIMEOUT → IDLE with oERR pulse; orate_control is kept.
- CLEAN:
  - Lasts exactly one cycle: oCLEAN=1, orate_control←0, FIFO flushed, → IDLE.
  - An iVALID byte during CLEAN is dropped silently.
- FIFO:
  - oWRen = not empty; oData = head.
  - Pop when oWRen & iREADY.
  - Push and pop in the same cycle when full → both succeed, no error.
  - Flush overrides pop and push.
- oTX_RATE_STATE = (state==CTRL). oSTART = (state!=CTRL), registered.

## Timing
- All outputs registered; there are no combinational paths from input to output.
- Reset values:
  - state IDLE, FIFO empty.
  - oWRen=0, oData=0, orate_control=0, oBUF_CNT=0.
  - oCLEAN=0, oERR=0, oTX_RATE_STATE=0, oSTART=0.
- oSTART rises in the first cycle after reset deasserts.
- Byte at cycle n:
  - State change, orate_control, oTX_RATE_STATE, oSTART, oCLEAN and oERR are visible at n+1.
  - A pushed byte appears on oData/oWRen at n+1 if the FIFO was empty.
- oCLEAN and oERR are high for exactly one cycle per event.
- Timeout: oERR and exit at cycle k+TIMEOUT, where k is the last byte or CTRL entry.
- Reset asserted mid-operation: immediate return to reset values, FIFO contents lost.

## Structure
- Package mode_ctrl_pkg:
  - state enum.
  - Char constants CH_M, CH_F, CH_C, CH_NUL.
  - Rate char table and function rate_index(byte) → {hit, index}.
- Sub-module cmd_fifo:
  - Synchronous FIFO, parameters DATA_W and BUF_DEPTH.
  - push/pop/flush inputs; count/full/empty outputs.
- Top contains the FSM, rate register, timeout counter and error pulse logic.

## Test plan
- Reset, then bytes 'h','i' with iREADY=1 → oData 0x68 then 0x69, oWRen one cycle each; orate_control=0; oSTART=1.
- 'M','5','F' → oTX_RATE_STATE=1 from the cycle after 'M'; orate_control=1 after '5'; IDLE and oSTART=1 after 'F'.
- NUM_RATES=3: 'M','B','Z' → two oERR pulses; orate_control unchanged; FIFO empty.
- iREADY=0, BUF_DEPTH=4, five data bytes → oBUF_CNT=4, oERR on the fifth byte; then iREADY=1 drains exactly the first four bytes in order.
- 'M','A','F', then 'x','C' → orate_control=2; after 'C', oCLEAN pulse, orate_control=0, FIFO flushed (oWRen=0).
- TIMEOUT=16: 'M' then no input → oERR and return to IDLE 16 cycles later. Also reset asserted during CTRL → all outputs at reset values.
